req_resp_responder: RTL and testbench

//   Responder side of the a->b handshake our assertion benches check with
//   "@(posedge clk) a ##[1:$] b". Every cycle with a=1 is one request, and the

---
 rtl/req_resp_responder.sv | 119 +++++++++++
 tb/tb_req_resp_responder.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/req_resp_responder.sv
// Request/response responder: every a=1 cycle is one request, answered by a
// one-cycle b pulse DELAY cycles later; optional assertions under RESP_SVA_EN.
module req_resp_responder #(
    parameter int  DELAY = 2,
    parameter int  DEPTH = 8,
    localparam int CW    = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          a,
    output logic          b,
    output logic [CW-1:0] pending,
    output logic          busy,
    output logic          overflow
);

    localparam int NW = $clog2(DELAY) + 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t        state, state_nxt;
    logic [NW-1:0] cnt, cnt_nxt;
    logic [CW-1:0] pending_nxt;
    logic          b_nxt;
    logic          b_set;
    logic          accept;
    logic          drop;

    // A full queue can still take a request on the edge that retires one.
    assign b_set  = (state == WAIT) && (cnt == '0);
    assign accept = a && ((pending < CW'(DEPTH)) || b_set);
    assign drop   = a && !accept;
    assign busy   = (state != IDLE);

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        b_nxt     = 1'b0;
        case (state)
            IDLE: begin
                if (accept || (pending != '0)) begin
                    state_nxt = WAIT;
                    cnt_nxt   = NW'(DELAY - 1);
                end
            end
            WAIT: begin
                if (cnt != '0) begin
                    cnt_nxt = cnt - NW'(1);
                end else begin
                    b_nxt     = 1'b1;
                    state_nxt = RESP;
                end
            end
            RESP: begin
                // pending here already reflects the retire done on the b edge
                if ((pending != '0) || accept) begin
                    state_nxt = WAIT;
                    cnt_nxt   = NW'(DELAY - 1);
                end else begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
                cnt_nxt   = '0;
            end
        endcase
    end

    always_comb begin
        pending_nxt = pending;
        case ({accept, b_set})
            2'b10:   pending_nxt = pending + CW'(1);
            2'b01:   pending_nxt = pending - CW'(1);
            default: pending_nxt = pending;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            cnt      <= '0;
            b        <= 1'b0;
            pending  <= '0;
            overflow <= 1'b0;
        end else begin
            state    <= state_nxt;
            cnt      <= cnt_nxt;
            b        <= b_nxt;
            pending  <= pending_nxt;
            if (drop) begin
                overflow <= 1'b1;
            end
        end
    end

`ifdef RESP_SVA_EN
    a_req_answered: assert property (@(posedge clk) disable iff (rst) a |-> ##[1:$] b)
        $info("a_req_answered pass t=%0t a=%b b=%b pending=%0d", $time, a, b, pending);
    else
        $error("a_req_answered fail t=%0t a=%b b=%b pending=%0d", $time, a, b, pending);

    a_b_single: assert property (@(posedge clk) disable iff (rst) b |=> !b)
        $info("a_b_single pass t=%0t a=%b b=%b pending=%0d", $time, a, b, pending);
    else
        $error("a_b_single fail t=%0t a=%b b=%b pending=%0d", $time, a, b, pending);

    a_pending_bound: assert property (@(posedge clk) disable iff (rst)
                                      !overflow |-> (pending <= CW'(DEPTH)))
        $info("a_pending_bound pass t=%0t a=%b b=%b pending=%0d", $time, a, b, pending);
    else
        $error("a_pending_bound fail t=%0t a=%b b=%b pending=%0d", $time, a, b, pending);
`endif

endmodule

// File: tb/tb_req_resp_responder.sv
// Directed bench for req_resp_responder: three instances (DELAY/DEPTH = 2/8, 2/4, 1/2)
// share clk, rst and a; each test resets all of them and checks one instance.
module tb_req_resp_responder;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       a   = 1'b0;

    logic       b8, busy8, ov8;
    logic [3:0] p8;
    logic       b4, busy4, ov4;
    logic [2:0] p4;
    logic       b1, busy1, ov1;
    logic [1:0] p1;

    int tests_run = 0;
    int tests_failed = 0;

    always #5 clk = ~clk;

    req_resp_responder #(.DELAY(2), .DEPTH(8)) u_dut8 (
        .clk(clk), .rst(rst), .a(a), .b(b8), .pending(p8), .busy(busy8), .overflow(ov8));
    req_resp_responder #(.DELAY(2), .DEPTH(4)) u_dut4 (
        .clk(clk), .rst(rst), .a(a), .b(b4), .pending(p4), .busy(busy4), .overflow(ov4));
    req_resp_responder #(.DELAY(1), .DEPTH(2)) u_dut1 (
        .clk(clk), .rst(rst), .a(a), .b(b1), .pending(p1), .busy(busy1), .overflow(ov1));

    task automatic tick;
        @(negedge clk);
    endtask

    task automatic do_reset;
        rst = 1'b1;
        a   = 1'b0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset;
        do_reset();
        tests_run++; if (b8 !== 1'b0)     begin tests_failed++; $display("FAIL reset_b8: got %b expected 0", b8); end
        tests_run++; if (p8 !== 4'd0)     begin tests_failed++; $display("FAIL reset_p8: got %0d expected 0", p8); end
        tests_run++; if (busy8 !== 1'b0)  begin tests_failed++; $display("FAIL reset_busy8: got %b expected 0", busy8); end
        tests_run++; if (ov8 !== 1'b0)    begin tests_failed++; $display("FAIL reset_ov8: got %b expected 0", ov8); end
        tests_run++; if (b4 !== 1'b0)     begin tests_failed++; $display("FAIL reset_b4: got %b expected 0", b4); end
        tests_run++; if (p4 !== 3'd0)     begin tests_failed++; $display("FAIL reset_p4: got %0d expected 0", p4); end
        tests_run++; if (busy4 !== 1'b0)  begin tests_failed++; $display("FAIL reset_busy4: got %b expected 0", busy4); end
        tests_run++; if (ov4 !== 1'b0)    begin tests_failed++; $display("FAIL reset_ov4: got %b expected 0", ov4); end
        tests_run++; if (b1 !== 1'b0)     begin tests_failed++; $display("FAIL reset_b1: got %b expected 0", b1); end
        tests_run++; if (p1 !== 2'd0)     begin tests_failed++; $display("FAIL reset_p1: got %0d expected 0", p1); end
    endtask

    // One request: b exactly DELAY edges after acceptance, busy drops one edge later.
    task automatic test_single;
        logic [0:5] ap = 6'b100000;
        logic [0:5] eb = 6'b001000;
        logic [0:5] ebz = 6'b111000;
        int         ep[6] = '{1, 1, 0, 0, 0, 0};
        do_reset();
        for (int k = 0; k < 6; k++) begin
            a = ap[k];
            tick();
            tests_run++; if (b8 !== eb[k])     begin tests_failed++; $display("FAIL single_b[%0d]: got %b expected %b", k, b8, eb[k]); end
            tests_run++; if (p8 !== 4'(ep[k])) begin tests_failed++; $display("FAIL single_pending[%0d]: got %0d expected %0d", k, p8, ep[k]); end
            tests_run++; if (busy8 !== ebz[k]) begin tests_failed++; $display("FAIL single_busy[%0d]: got %b expected %b", k, busy8, ebz[k]); end
        end
    endtask

    // Three consecutive requests; the third arrives on the first b edge, so the count holds at 2.
    task automatic test_back_to_back;
        logic [0:10] ap  = 11'b11100000000;
        logic [0:10] eb  = 11'b00100100100;
        logic [0:10] ebz = 11'b11111111100;
        int          ep[11] = '{1, 2, 2, 2, 2, 1, 1, 1, 0, 0, 0};
        do_reset();
        for (int k = 0; k < 11; k++) begin
            a = ap[k];
            tick();
            tests_run++; if (b8 !== eb[k])     begin tests_failed++; $display("FAIL b2b_b[%0d]: got %b expected %b", k, b8, eb[k]); end
            tests_run++; if (p8 !== 4'(ep[k])) begin tests_failed++; $display("FAIL b2b_pending[%0d]: got %0d expected %0d", k, p8, ep[k]); end
            tests_run++; if (busy8 !== ebz[k]) begin tests_failed++; $display("FAIL b2b_busy[%0d]: got %b expected %b", k, busy8, ebz[k]); end
        end
    endtask

    // DEPTH=4, a held 8 cycles: first drop at edge 6 (RESP, queue full), overflow then sticks.
    task automatic test_overflow;
        logic [0:19] ap  = 20'b11111111000000000000;
        logic [0:19] eb  = 20'b00100100100100100100;
        logic [0:19] eov = 20'b00000011111111111111;
        int          ep[20] = '{1, 2, 2, 3, 4, 4, 4, 4, 3, 3, 3, 2, 2, 2, 1, 1, 1, 0, 0, 0};
        do_reset();
        for (int k = 0; k < 20; k++) begin
            a = ap[k];
            tick();
            tests_run++; if (b4 !== eb[k])     begin tests_failed++; $display("FAIL ovf_b[%0d]: got %b expected %b", k, b4, eb[k]); end
            tests_run++; if (p4 !== 3'(ep[k])) begin tests_failed++; $display("FAIL ovf_pending[%0d]: got %0d expected %0d", k, p4, ep[k]); end
            tests_run++; if (ov4 !== eov[k])   begin tests_failed++; $display("FAIL ovf_flag[%0d]: got %b expected %b", k, ov4, eov[k]); end
        end
    endtask

    // DEPTH=4, a held 6 cycles: the 6th request lands on a b edge with pending=4 and is taken.
    task automatic test_full_same_edge;
        logic [0:19] ap = 20'b11111100000000000000;
        logic [0:19] eb = 20'b00100100100100100100;
        int          ep[20] = '{1, 2, 2, 3, 4, 4, 4, 4, 3, 3, 3, 2, 2, 2, 1, 1, 1, 0, 0, 0};
        do_reset();
        for (int k = 0; k < 20; k++) begin
            a = ap[k];
            tick();
            tests_run++; if (b4 !== eb[k])     begin tests_failed++; $display("FAIL full_b[%0d]: got %b expected %b", k, b4, eb[k]); end
            tests_run++; if (p4 !== 3'(ep[k])) begin tests_failed++; $display("FAIL full_pending[%0d]: got %0d expected %0d", k, p4, ep[k]); end
            tests_run++; if (ov4 !== 1'b0)     begin tests_failed++; $display("FAIL full_overflow[%0d]: got %b expected 0", k, ov4); end
        end
    endtask

    task automatic test_reset_mid_service;
        int b_seen = 0;
        do_reset();
        a = 1'b1;
        for (int k = 0; k < 4; k++) tick();
        tests_run++; if (p8 !== 4'd3)   begin tests_failed++; $display("FAIL midrst_pre_pending: got %0d expected 3", p8); end
        tests_run++; if (busy8 !== 1'b1) begin tests_failed++; $display("FAIL midrst_pre_busy: got %b expected 1", busy8); end
        a   = 1'b0;
        rst = 1'b1;
        tick();
        tests_run++; if (b8 !== 1'b0)    begin tests_failed++; $display("FAIL midrst_b: got %b expected 0", b8); end
        tests_run++; if (p8 !== 4'd0)    begin tests_failed++; $display("FAIL midrst_pending: got %0d expected 0", p8); end
        tests_run++; if (busy8 !== 1'b0) begin tests_failed++; $display("FAIL midrst_busy: got %b expected 0", busy8); end
        rst = 1'b0;
        for (int k = 0; k < 12; k++) begin
            tick();
            if (b8 === 1'b1) b_seen++;
        end
        tests_run++; if (b_seen !== 0) begin tests_failed++; $display("FAIL midrst_no_b: got %0d pulses expected 0", b_seen); end
        tests_run++; if (p8 !== 4'd0)  begin tests_failed++; $display("FAIL midrst_post_pending: got %0d expected 0", p8); end
    endtask

    // DELAY=1: b follows acceptance by one edge; back-to-back requests spaced 2 cycles.
    task automatic test_delay1;
        logic [0:5] ap  = 6'b110000;
        logic [0:5] eb  = 6'b010100;
        logic [0:5] ebz = 6'b111100;
        int         ep[6] = '{1, 1, 1, 0, 0, 0};
        do_reset();
        for (int k = 0; k < 6; k++) begin
            a = ap[k];
            tick();
            tests_run++; if (b1 !== eb[k])     begin tests_failed++; $display("FAIL d1_b[%0d]: got %b expected %b", k, b1, eb[k]); end
            tests_run++; if (p1 !== 2'(ep[k])) begin tests_failed++; $display("FAIL d1_pending[%0d]: got %0d expected %0d", k, p1, ep[k]); end
            tests_run++; if (busy1 !== ebz[k]) begin tests_failed++; $display("FAIL d1_busy[%0d]: got %b expected %b", k, busy1, ebz[k]); end
        end
    endtask

    task automatic test_random;
        logic       prev_b;
        logic [3:0] prev_p;
        do_reset();
        prev_b = b8;
        prev_p = p8;
        for (int k = 0; k < 1000; k++) begin
            a = 1'($urandom_range(0, 1));
            tick();
            tests_run++; if (p8 > 4'd8) begin tests_failed++; $display("FAIL rnd_bound[%0d]: got %0d expected <= 8", k, p8); end
            tests_run++; if (b8 && prev_b) begin tests_failed++; $display("FAIL rnd_b_twice[%0d]: got b=1 twice expected single pulse", k); end
            tests_run++; if (b8 && (prev_p == 4'd0)) begin tests_failed++; $display("FAIL rnd_b_empty[%0d]: got b=1 with pending 0 expected b=0", k); end
            prev_b = b8;
            prev_p = p8;
        end
        a = 1'b0;
        for (int k = 0; k < 40; k++) tick();
        tests_run++; if (p8 !== 4'd0)    begin tests_failed++; $display("FAIL rnd_drain_pending: got %0d expected 0", p8); end
        tests_run++; if (busy8 !== 1'b0) begin tests_failed++; $display("FAIL rnd_drain_busy: got %b expected 0", busy8); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_overflow();
        test_full_same_edge();
        test_reset_mid_service();
        test_delay1();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
